// File: rtl/bus_stepper_if.sv
// Bus sequencer interface: start/stall/skip controls in, step lines and clock phases out.
// The stepper side uses the slave modport; the controlling logic uses master.
interface bus_stepper_if #(
  parameter int unsigned NSTEPS = 6
);
  logic              wgo;
  logic              whold;
  logic              wskip;
  logic [NSTEPS-1:0] bsteps;
  logic              wclke;
  logic              wclks;
  logic              wbusy;
  logic              wlast;

  modport master (
    output wgo, whold, wskip,
    input  bsteps, wclke, wclks, wbusy, wlast
  );

  modport slave (
    input  wgo, whold, wskip,
    output bsteps, wclke, wclks, wbusy, wlast
  );
endinterface

// File: rtl/bus_stepper.sv
// Step sequencer for the 8-bit bus datapath: NSTEPS one-hot steps of 4 clock phases each.
// Optional debug gate BUS_STEPPER_SINGLE_STEP_EN adds a wstep input that must be high to leave p3.
module bus_stepper #(
  parameter int unsigned NSTEPS = 6
) (
  input logic          wclk,
  input logic          wrst,
`ifdef BUS_STEPPER_SINGLE_STEP_EN
  input logic          wstep,
`endif
  bus_stepper_if.slave bus
);

  localparam int unsigned SW = $clog2(NSTEPS);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     step_q, step_d;
  logic [1:0]        phase_q, phase_d;
  logic [NSTEPS-1:0] bsteps_q, bsteps_d;
  logic              clke_q, clke_d;
  logic              clks_q, clks_d;
  logic              busy_q, busy_d;

  logic stall;
  logic last_step;
  logic seq_end;

`ifdef BUS_STEPPER_SINGLE_STEP_EN
  assign stall = bus.whold | ~wstep;
`else
  assign stall = bus.whold;
`endif
  assign last_step = (step_q == SW'(NSTEPS - 1));
  assign seq_end   = last_step | bus.wskip;

  // State and registered outputs.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q  <= StIdle;
      step_q   <= '0;
      phase_q  <= '0;
      bsteps_q <= '0;
      clke_q   <= 1'b0;
      clks_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      phase_q  <= phase_d;
      bsteps_q <= bsteps_d;
      clke_q   <= clke_d;
      clks_q   <= clks_d;
      busy_q   <= busy_d;
    end
  end

  // Next state: only p3 of a running step looks at hold/skip/go.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    phase_d = phase_q;
    unique case (state_q)
      StIdle: begin
        if (bus.wgo) begin
          state_d = StRun;
          step_d  = '0;
          phase_d = '0;
        end
      end
      StRun: begin
        if (phase_q != 2'd3) begin
          phase_d = phase_q + 2'd1;
        end else if (stall) begin
          phase_d = phase_q;
        end else if (seq_end) begin
          step_d  = '0;
          phase_d = '0;
          if (!bus.wgo) state_d = StIdle;
        end else begin
          step_d  = step_q + SW'(1);
          phase_d = '0;
        end
      end
    endcase
  end

  // Outputs decoded from next state so they leave the flops glitch-free.
  always_comb begin
    bsteps_d = '0;
    clke_d   = 1'b0;
    clks_d   = 1'b0;
    busy_d   = 1'b0;
    if (state_d == StRun) begin
      bsteps_d[step_d] = 1'b1;
      clke_d           = (phase_d != 2'd3);
      clks_d           = (phase_d == 2'd1);
      busy_d           = 1'b1;
    end
  end

  assign bus.bsteps = bsteps_q;
  assign bus.wclke  = clke_q;
  assign bus.wclks  = clks_q;
  assign bus.wbusy  = busy_q;
  // wskip is sampled in p3, so wlast has to reflect it in that same cycle.
  assign bus.wlast  = busy_q & (phase_q == 2'd3) & (last_step | bus.wskip);

endmodule

// File: tb/tb_bus_stepper.sv
// Scoreboard bench for bus_stepper: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_bus_stepper;
  localparam int unsigned NS = 6;

  typedef struct packed {
    logic [NS-1:0] b;
    logic          e;
    logic          s;
    logic          busy;
    logic          last;
  } exp_t;

  logic wclk = 1'b0;
  logic wrst;
`ifdef BUS_STEPPER_SINGLE_STEP_EN
  logic wstep;
`endif

  bus_stepper_if #(.NSTEPS(NS)) bus ();

  bus_stepper #(.NSTEPS(NS)) dut (
    .wclk  (wclk),
    .wrst  (wrst),
`ifdef BUS_STEPPER_SINGLE_STEP_EN
    .wstep (wstep),
`endif
    .bus   (bus.slave)
  );

  always #5 wclk = ~wclk;

  exp_t  expq[$];
  string tagq[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  exp_t  mon_ex;
  exp_t  mon_act;
  string mon_tag;

  always @(negedge wclk) begin
    if (expq.size() != 0) begin
      mon_ex  = expq.pop_front();
      mon_tag = tagq.pop_front();
      mon_act = {bus.bsteps, bus.wclke, bus.wclks, bus.wbusy, bus.wlast};
      n_chk++;
      if (mon_act === mon_ex) n_pass++;
      else
        $display("FAIL %s @%0t: got bsteps=%b e=%b s=%b busy=%b last=%b, want bsteps=%b e=%b s=%b busy=%b last=%b",
                 mon_tag, $time, mon_act.b, mon_act.e, mon_act.s, mon_act.busy, mon_act.last,
                 mon_ex.b, mon_ex.e, mon_ex.s, mon_ex.busy, mon_ex.last);
    end
  end

  // Expected outputs for step k (0-based), phase p: e/s = 10,11,10,00.
  function automatic exp_t run_x(input int k, input int p, input bit last);
    exp_t x;
    x      = '0;
    x.b[k] = 1'b1;
    x.e    = (p != 3);
    x.s    = (p == 1);
    x.busy = 1'b1;
    x.last = last;
    return x;
  endfunction

  // One clock cycle: apply inputs, queue what the outputs must be during it.
  task automatic cyc(input string tag, input bit rst, input bit go, input bit hold,
                     input bit skip, input exp_t ex);
    wrst      = rst;
    bus.wgo   = go;
    bus.whold = hold;
    bus.wskip = skip;
    expq.push_back(ex);
    tagq.push_back(tag);
    @(posedge wclk);
    #1;
  endtask

  task automatic ph(input string tag, input int k, input int p, input bit go, input bit hold,
                    input bit skip, input bit last);
    cyc(tag, 1'b0, go, hold, skip, run_x(k, p, last));
  endtask

  // Full steps kf..kt with no hold/skip; wlast only in p3 of the final step.
  task automatic run_range(input string tag, input int kf, input int kt, input bit go);
    for (int k = kf; k <= kt; k++)
      for (int p = 0; p < 4; p++)
        ph(tag, k, p, go, 1'b0, 1'b0, (k == NS - 1) && (p == 3));
  endtask

  task automatic idle(input string tag, input bit go);
    cyc(tag, 1'b0, go, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst      = 1'b1;
    bus.wgo   = 1'b0;
    bus.whold = 1'b0;
    bus.wskip = 1'b0;
`ifdef BUS_STEPPER_SINGLE_STEP_EN
    wstep     = 1'b1;
`endif
    repeat (2) @(posedge wclk);
    #1;

    idle("reset", 1'b0);
    idle("idle", 1'b0);

    // Single go pulse: 24 run cycles then idle.
    idle("go_pulse", 1'b1);
    run_range("seq", 0, NS - 1, 1'b0);
    idle("seq_end", 1'b0);

    // go held high: restarts at step 1 with no bubble.
    idle("b2b_go", 1'b1);
    run_range("b2b_a", 0, NS - 1, 1'b1);
    run_range("b2b_b", 0, NS - 1, 1'b0);
    idle("b2b_end", 1'b0);

    // Hold three cycles at step 2 p3.
    idle("hold_go", 1'b1);
    run_range("hold", 0, 0, 1'b0);
    for (int p = 0; p < 3; p++) ph("hold", 1, p, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ph("hold_p3", 1, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    ph("hold_rel", 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_range("hold", 2, NS - 1, 1'b0);
    idle("hold_end", 1'b0);

    // Skip at step 3 p3, go low: idle after 12 cycles.
    idle("skip_go", 1'b1);
    run_range("skip", 0, 1, 1'b0);
    for (int p = 0; p < 3; p++) ph("skip", 2, p, 1'b0, 1'b0, 1'b0, 1'b0);
    ph("skip_p3", 2, 3, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("skip_end", 1'b0);

    // Hold and skip together: hold wins, skip dropped next cycle so the step advances.
    idle("hs_go", 1'b1);
    run_range("hs", 0, 0, 1'b0);
    for (int p = 0; p < 3; p++) ph("hs", 1, p, 1'b0, 1'b0, 1'b0, 1'b0);
    ph("hs_both", 1, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    ph("hs_rel", 1, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    run_range("hs", 2, NS - 1, 1'b0);
    idle("hs_end", 1'b0);

    // Skip with go high restarts immediately.
    idle("sk_b2b_go", 1'b1);
    for (int p = 0; p < 3; p++) ph("sk_b2b", 0, p, 1'b0, 1'b0, 1'b0, 1'b0);
    ph("sk_b2b_p3", 0, 3, 1'b1, 1'b0, 1'b1, 1'b1);
    run_range("sk_b2b_re", 0, NS - 1, 1'b0);
    idle("sk_b2b_end", 1'b0);

    // Reset at step 4 p1, then restart from step 1.
    idle("rst_go", 1'b1);
    run_range("rst", 0, 2, 1'b0);
    ph("rst", 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rst_p1", 1'b1, 1'b0, 1'b0, 1'b0, run_x(3, 1, 1'b0));
    idle("rst_after", 1'b0);
    idle("rst_rego", 1'b1);
    run_range("rst_re", 0, NS - 1, 1'b0);
    idle("rst_end", 1'b0);

`ifdef BUS_STEPPER_SINGLE_STEP_EN
    // wstep low stalls at p3; raising it advances.
    idle("ss_go", 1'b1);
    for (int p = 0; p < 3; p++) ph("ss", 0, p, 1'b0, 1'b0, 1'b0, 1'b0);
    wstep = 1'b0;
    ph("ss_stall", 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    ph("ss_stall", 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    wstep = 1'b1;
    ph("ss_adv", 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    ph("ss_next", 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("ss_rst", 1'b1, 1'b0, 1'b0, 1'b0, run_x(1, 1, 1'b0));
    idle("ss_end", 1'b0);
`endif

    n_chk++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", expq.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
